mas_alu_res_queue: RTL
======================

MAS_ALU_RES_QUEUE -- requirements
Module: mas_alu_res_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of result entries; power of two, >= 2.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  execution-unit result present; driven by the unit's ready output.
REQ-005 in_res  input  `MAS_BLEN  execution-unit result (e.g. shift res).
REQ-006 in_ready  output  1  queue can accept a push this cycle.
REQ-007 out_valid  output  1  head entry available to consumer.
REQ-008 out_res  output  `MAS_BLEN  head entry data.
REQ-009 out_ready  input  1  consumer accepts head this cycle.
REQ-010 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-011 Push SHALL occur when in_valid && in_ready at posedge; pop SHALL occur when out_valid && out_ready at posedge.
REQ-012 in_ready SHALL equal (count != DEPTH), combinational from registered count only; no full-time pass-through.
REQ-013 out_valid SHALL equal (count != 0); out_res SHALL be storage[rd_ptr], valid whenever out_valid is 1.
REQ-014 Latency: a push into an empty queue SHALL assert out_valid with that data on the next cycle; no same-cycle bypass.
REQ-015 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; FIFO order is preserved.
REQ-016 Push while full SHALL be refused (in_ready=0); storage, pointers and count SHALL be unchanged.
REQ-017 Pop while empty SHALL be impossible (out_valid=0); out_ready is ignored when empty.
REQ-018 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-019 Data SHALL be stored unmodified, full `MAS_BLEN width; no arithmetic on data.
REQ-020 out_res SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-021 On rst_n low, wr_ptr, rd_ptr and count SHALL clear to 0 asynchronously; out_valid=0, in_ready=1 in the same cycle.
REQ-022 Storage SHALL reset to 0, so out_res reads 0 during and after reset until the first push.
REQ-023 Reset mid-operation SHALL discard all entries; no push or pop is performed in the release cycle unless rst_n is high at that posedge.

Configuration
REQ-024 Macro MAS_ALU_RESQ_OVF_EN, when defined, SHALL add output ovf (1 bit): sticky, set on the posedge after any cycle with in_valid && !in_ready, cleared only by reset.
REQ-025 Without MAS_ALU_RESQ_OVF_EN, port ovf SHALL be absent, and refused pushes SHALL be silently dropped with no other side effect.

Structure
REQ-026 Package mas_alu_pkg SHALL hold MAS_ALU_RESQ_DEPTH (default 4) and typedefs for the pointer and count widths derived from it.
REQ-027 `MAS_BLEN SHALL be taken from the existing shared define; no local redefinition.
REQ-028 No sub-module; storage array, pointers and counter SHALL be inline, single always_ff for state.

Verification (MAS_BLEN=32, DEPTH=4)
REQ-029 Reset release, no stimulus -> count=0, out_valid=0, in_ready=1, out_res=0.
REQ-030 Push 0x0000_0010 with out_ready=0 -> next cycle out_valid=1, out_res=0x0000_0010, count=1; holds stable for 5 cycles.
REQ-031 Push 0x1,0x2,0x3,0x4 then a fifth value 0x5, out_ready=0 -> count=4, in_ready=0, 0x5 discarded; pops return 0x1..0x4 in order; ovf=1 when MAS_ALU_RESQ_OVF_EN is defined.
REQ-032 With count=2, push 0xAAAA_5555 and pop in the same cycle -> count stays 2; the popped value is the old head; 0xAAAA_5555 emerges after the remaining entry.
REQ-033 Ten push/pop cycles of 0x0..0x9 with both pointers wrapping twice -> output sequence 0x0..0x9, no loss or duplication.
REQ-034 Assert rst_n low with count=3 -> count=0 and out_valid=0 immediately (before the next clk edge), and ovf=0.

Source files
------------

// File: rtl/mas_alu_pkg.sv
// Shared definitions for the mas_alu result queue.
//
// Contents:
//   MAS_BLEN             shared data-width define. It is supplied by the project's
//                        common define set. The 32-bit fallback only applies when
//                        this package is compiled on its own.
//   MAS_ALU_RESQ_DEPTH   default number of result-queue entries (power of two, >= 2).
//   resq_ptr_t           read/write pointer type for the default depth.
//   resq_cnt_t           occupancy type for the default depth (holds 0..DEPTH).
`ifndef MAS_BLEN
`define MAS_BLEN 32
`endif

package mas_alu_pkg;

    localparam int MAS_ALU_RESQ_DEPTH = 4;
    localparam int MAS_ALU_RESQ_PTR_W = $clog2(MAS_ALU_RESQ_DEPTH);
    localparam int MAS_ALU_RESQ_CNT_W = MAS_ALU_RESQ_PTR_W + 1;

    typedef logic [MAS_ALU_RESQ_PTR_W-1:0] resq_ptr_t;
    typedef logic [MAS_ALU_RESQ_CNT_W-1:0] resq_cnt_t;

endpackage

// File: rtl/mas_alu_res_queue.sv
// mas_alu_res_queue: small FIFO that buffers execution-unit results for the
// downstream consumer.
//
// Ports:
//   clk        sole clock; all state updates on its rising edge
//   rst_n      asynchronous active-low reset; clears pointers, count and storage
//   in_valid   a result is offered by the execution unit
//   in_res     result data, `MAS_BLEN bits
//   in_ready   the queue accepts a push this cycle (count != DEPTH)
//   out_valid  the head entry is available (count != 0)
//   out_res    head entry data
//   out_ready  the consumer takes the head this cycle
//   count      current occupancy, 0..DEPTH
//   ovf        (only with MAS_ALU_RESQ_OVF_EN) sticky flag set after any refused
//              push; only reset clears it
//
// Build option:
//   MAS_ALU_RESQ_OVF_EN  adds the ovf output. Without it, a refused push is dropped
//                        and has no side effect.
//
// Behaviour:
//   - No bypass path. A push into an empty queue appears on out_res on the next
//     cycle.
//   - in_ready and out_valid decode only the registered count, so neither output
//     depends combinationally on an input.
module mas_alu_res_queue
    import mas_alu_pkg::*;
#(
    parameter int DEPTH = MAS_ALU_RESQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [`MAS_BLEN-1:0]      in_res,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [`MAS_BLEN-1:0]      out_res,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
`ifdef MAS_ALU_RESQ_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [`MAS_BLEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_res   = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 by
    // natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`ifdef MAS_ALU_RESQ_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_res;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
`ifdef MAS_ALU_RESQ_OVF_EN
            if (in_valid && !in_ready) begin
                ovf <= 1'b1;
            end
`endif
        end
    end

endmodule
